// File: rtl/tp_mon_pkg.sv
// Shared types and defaults for the test-point pad monitor: FSM state encoding,
// default parameter values and the read-select width helper.
package tp_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } mon_state_t;

    localparam int DEF_N_CH    = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_WIN_W   = 24;
    localparam int DEF_STRETCH = 4;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tp_mon_chan.sv
// One test-point channel: 2-flop sync, rising-edge detect, saturating counter with sticky
// overflow, and the mirror output (pulse-stretched when TP_MON_STRETCH_EN is defined).
module tp_mon_chan #(
    parameter int CNT_W   = 16
`ifdef TP_MON_STRETCH_EN
    ,
    parameter int STRETCH = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tp,
    input  logic             count_en,
    input  logic             arm,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             mirror
);

    logic sync0;
    logic s1;
    logic s2;
    logic rise;
    logic inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            s1    <= 1'b0;
            s2    <= 1'b0;
        end else begin
            sync0 <= tp;
            s1    <= sync0;
            s2    <= s1;
        end
    end

    assign rise = s1 & ~s2;
    assign inc  = rise & count_en;

    // arm beats rd_clr; a rise coinciding with rd_clr lands on the freshly cleared counter.
    always_ff @(posedge clk) begin
        if (reset || arm) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= CNT_W'(inc);
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef TP_MON_STRETCH_EN
    localparam int ST_W = $clog2(STRETCH + 1);
    logic [ST_W-1:0] st_cnt;

    // s1 covers the first high cycle; st_cnt holds the mirror for the remaining STRETCH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_cnt <= '0;
        end else if (rise) begin
            st_cnt <= ST_W'(STRETCH - 1);
        end else if (st_cnt != '0) begin
            st_cnt <= st_cnt - ST_W'(1);
        end
    end

    assign mirror = s1 | (st_cnt != '0);
`else
    assign mirror = s1;
`endif

endmodule

// File: rtl/tp_pad_monitor.sv
// Test-point monitor top: window FSM, per-channel counters, one-cycle read port (no backpressure).
// Optional mirror pulse stretching is built only when TP_MON_STRETCH_EN is defined.
module tp_pad_monitor
    import tp_mon_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int STRETCH = DEF_STRETCH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          tp_in,
    input  logic [WIN_W-1:0]         win_len,
    input  logic                     arm,
    output logic                     busy,
    output logic                     done,
    input  logic                     rd_req,
    input  logic [sel_w(N_CH)-1:0]   rd_sel,
    input  logic                     rd_clr,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     rd_ovf,
    output logic [N_CH-1:0]          tp_mirror
);

    localparam int SEL_W = sel_w(N_CH);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("tp_pad_monitor: N_CH must be 1..32");
    end
    if (STRETCH < 1) begin : g_bad_stretch
        $error("tp_pad_monitor: STRETCH must be >= 1");
    end

    mon_state_t       state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  ovf;
    logic             count_en;
    logic             sel_ok;

    assign count_en = (state == COUNT);
    assign sel_ok   = (int'(rd_sel) < N_CH);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        tp_mon_chan #(
            .CNT_W   (CNT_W)
`ifdef TP_MON_STRETCH_EN
            ,
            .STRETCH (STRETCH)
`endif
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .tp       (tp_in[i]),
            .count_en (count_en),
            .arm      (arm),
            .clr      (rd_req & rd_clr & sel_ok & (rd_sel == SEL_W'(i))),
            .cnt      (cnt[i]),
            .ovf      (ovf[i]),
            .mirror   (tp_mirror[i])
        );
    end

    // win_cnt counts down to zero, so COUNT spans max(win_len,1) cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            win_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (arm) begin
            state   <= COUNT;
            win_cnt <= (win_len == '0) ? '0 : win_len - WIN_W'(1);
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                COUNT: begin
                    if (win_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt - WIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (sel_ok) begin
                    rd_data <= cnt[rd_sel];
                    rd_ovf  <= ovf[rd_sel];
                end else begin
                    rd_data <= '0;
                    rd_ovf  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tp_pad_monitor.sv
// Directed bench for tp_pad_monitor: N_CH=6 (leaves out-of-range select codes), CNT_W=4.
module tb_tp_pad_monitor;

    localparam int N_CH    = 6;
    localparam int CNT_W   = 4;
    localparam int WIN_W   = 8;
    localparam int STRETCH = 4;
`ifdef TP_MON_STRETCH_EN
    localparam int MIRROR_HIGH = STRETCH;
`else
    localparam int MIRROR_HIGH = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [N_CH-1:0]  tp_in;
    logic [WIN_W-1:0] win_len;
    logic             arm;
    logic             busy;
    logic             done;
    logic             rd_req;
    logic [2:0]       rd_sel;
    logic             rd_clr;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic [N_CH-1:0]  tp_mirror;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tp_pad_monitor #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W),
        .STRETCH (STRETCH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tp_in     (tp_in),
        .win_len   (win_len),
        .arm       (arm),
        .busy      (busy),
        .done      (done),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .rd_clr    (rd_clr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ovf    (rd_ovf),
        .tp_mirror (tp_mirror)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            tp_in[ch] = 1'b1;
            tick();
            tp_in[ch] = 1'b0;
            tick();
        end
    endtask

    task automatic arm_win(input int len);
        win_len = WIN_W'(len);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_read(input int sel, input logic clr);
        rd_sel = 3'(sel);
        rd_clr = clr;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_clr = 1'b0;
    endtask

    // Bounded: returns the number of ticks until done, or 400 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
        checks++; if (rd_ovf !== 1'b0) begin errors++; $display("FAIL reset_rd_ovf got %b want 0", rd_ovf); end
        checks++; if (tp_mirror !== '0) begin errors++; $display("FAIL reset_mirror got %b want 0", tp_mirror); end
    endtask

    task automatic test_basic_window();
        int n;
        arm_win(100);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b done=%b want 1/0", busy, done); end
        pulse(0, 10);
        wait_done(n);
        checks++; if (n !== 80) begin errors++; $display("FAIL basic_window_len got %0d want 80 ticks after pulses", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
        do_read(0, 1'b0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid got %b want 1", rd_valid); end
        checks++; if (rd_data !== 4'd10) begin errors++; $display("FAIL basic_rd_data got %0d want 10", rd_data); end
        checks++; if (rd_ovf !== 1'b0) begin errors++; $display("FAIL basic_rd_ovf got %b want 0", rd_ovf); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", rd_valid); end
        checks++; if (rd_data !== 4'd10) begin errors++; $display("FAIL basic_data_hold got %0d want 10", rd_data); end
    endtask

    task automatic test_saturate();
        int n;
        arm_win(100);
        pulse(3, 20);
        wait_done(n);
        checks++; if (n !== 60) begin errors++; $display("FAIL sat_window_len got %0d want 60", n); end
        do_read(0, 1'b0);
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL sat_arm_cleared_ch0 got %0d want 0", rd_data); end
        do_read(3, 1'b0);
        checks++; if (rd_data !== 4'd15 || rd_ovf !== 1'b1) begin errors++; $display("FAIL sat_read got data=%0d ovf=%b want 15/1", rd_data, rd_ovf); end
        do_read(3, 1'b1);
        checks++; if (rd_data !== 4'd15 || rd_ovf !== 1'b1) begin errors++; $display("FAIL sat_clr_read got data=%0d ovf=%b want 15/1", rd_data, rd_ovf); end
        do_read(3, 1'b0);
        checks++; if (rd_data !== 4'd0 || rd_ovf !== 1'b0) begin errors++; $display("FAIL sat_after_clr got data=%0d ovf=%b want 0/0", rd_data, rd_ovf); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL sat_b2b_valid got %b want 1", rd_valid); end
    endtask

    task automatic test_window_gate();
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse(1, 3);
        ticks(4);
        do_read(1, 1'b0);
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL gate_pre_arm got %0d want 0", rd_data); end
        arm_win(20);
        pulse(1, 4);
        wait_done(n);
        checks++; if (n !== 12) begin errors++; $display("FAIL gate_window_len got %0d want 12", n); end
        pulse(1, 5);
        ticks(4);
        do_read(1, 1'b0);
        checks++; if (rd_data !== 4'd4) begin errors++; $display("FAIL gate_post_done got %0d want 4", rd_data); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gate_done_held got %b want 1", done); end
    endtask

    task automatic test_clr_race();
        arm_win(200);
        pulse(2, 5);
        ticks(4);
        // Rise reaches the counter on the same edge the clearing read is taken.
        tp_in[2] = 1'b1;
        tick();
        tp_in[2] = 1'b0;
        tick();
        do_read(2, 1'b1);
        checks++; if (rd_data !== 4'd5 || rd_ovf !== 1'b0) begin errors++; $display("FAIL race_clr_read got data=%0d ovf=%b want 5/0", rd_data, rd_ovf); end
        do_read(2, 1'b0);
        checks++; if (rd_data !== 4'd1) begin errors++; $display("FAIL race_post_clr got %0d want 1", rd_data); end
        do_read(N_CH, 1'b0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 4'd0 || rd_ovf !== 1'b0) begin errors++; $display("FAIL race_bad_sel got valid=%b data=%0d ovf=%b want 1/0/0", rd_valid, rd_data, rd_ovf); end
        // arm and a clearing read in the same cycle: read returns the old value, all cleared.
        win_len = WIN_W'(200);
        arm = 1'b1;
        do_read(2, 1'b1);
        arm = 1'b0;
        checks++; if (rd_data !== 4'd1) begin errors++; $display("FAIL race_arm_clr_read got %0d want 1", rd_data); end
        do_read(2, 1'b0);
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL race_arm_wins got %0d want 0", rd_data); end
    endtask

    task automatic test_reset_mid();
        int n;
        pulse(0, 3);
        ticks(3);
        do_read(0, 1'b0);
        checks++; if (rd_data !== 4'd3 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre_reset got data=%0d busy=%b want 3/1", rd_data, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_state got busy=%b done=%b want 0/0", busy, done); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 4'd0) begin errors++; $display("FAIL mid_reset_rd got valid=%b data=%0d want 0/0", rd_valid, rd_data); end
        do_read(0, 1'b0);
        checks++; if (rd_data !== 4'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", rd_data); end
        arm_win(5);
        wait_done(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mid_rearm_len got %0d want 5", n); end
        arm_win(0);
        wait_done(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL zero_len_window got %0d want 1", n); end
    endtask

    task automatic test_mirror();
        int first;
        int highs;
        logic [N_CH-1:0] others;
        ticks(6);
        tp_in[4] = 1'b1;
        tick();
        tp_in[4] = 1'b0;
        first = 0;
        highs = 0;
        others = '0;
        for (int i = 1; i <= 10; i++) begin
            if (tp_mirror[4]) begin
                highs++;
                if (first == 0) first = i;
            end
            others = others | (tp_mirror & ~(N_CH'(1) << 4));
            tick();
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL mirror_latency got %0d want 2", first); end
        checks++; if (highs !== MIRROR_HIGH) begin errors++; $display("FAIL mirror_width got %0d want %0d", highs, MIRROR_HIGH); end
        checks++; if (others !== '0) begin errors++; $display("FAIL mirror_other_bits got %b want 0", others); end
    endtask

    initial begin
        reset   = 1'b1;
        tp_in   = '0;
        win_len = '0;
        arm     = 1'b0;
        rd_req  = 1'b0;
        rd_sel  = '0;
        rd_clr  = 1'b0;
        test_reset();
        test_basic_window();
        test_saturate();
        test_window_gate();
        test_clr_race();
        test_reset_mid();
        test_mirror();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
